// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode codes, result width helper and the status flag bundle.
package alu_pkg;

  localparam logic [2:0] OP_0 = 3'b000;
  localparam logic [2:0] OP_1 = 3'b001;
  localparam logic [2:0] OP_2 = 3'b010;
  localparam logic [2:0] OP_3 = 3'b011;
  localparam logic [2:0] OP_4 = 3'b100;
  localparam logic [2:0] OP_5 = 3'b101;
  localparam logic [2:0] OP_6 = 3'b110;
  localparam logic [2:0] OP_7 = 3'b111;

  // The operation mux widens N-bit operands by three bits.
  function automatic int result_w(input int n);
    return n + 3;
  endfunction

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } flag_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative/N-bit-overflow flags for a W = N+3 bit signed result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int N = 4,
  parameter int W = result_w(N)
) (
  input  logic [W-1:0] result,
  output flag_t        flags
);

  // The value fits in N signed bits only when the top W-N+1 bits are a pure sign extension.
  logic [W-N:0] top;
  assign top = result[W-1:N-1];

  assign flags.zero = (result == '0);
  assign flags.neg  = result[W-1];
  assign flags.ovf  = !((&top) || !(|top));

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry elastic output buffer behind the ALU mux; flags are captured at push.
// Optional statistics counters are built only when ALU_STATS_EN is defined.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2,
  parameter int W     = result_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_sel,
  input  logic [W-1:0] in_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_sel,
  output logic [W-1:0] out_result,
  output logic         out_zero,
  output logic         out_neg,
  output logic         out_ovf,
  input  logic         stat_clr,
  output logic [15:0]  stat_count,
  output logic [15:0]  stat_ovf_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state, state_nx;
  logic         push, pop;
  logic         load_head_in, load_head_slot, load_slot;
  flag_t        in_flags, head_flags, slot_flags;
  logic [2:0]   slot_sel;
  logic [W-1:0] slot_result;

  alu_flag_gen #(.N(N), .W(W)) u_flag_gen (
    .result (in_result),
    .flags  (in_flags)
  );

  assign in_ready  = (2'(state) != 2'(DEPTH));
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nx       = state;
    load_head_in   = 1'b0;
    load_head_slot = 1'b0;
    load_slot      = 1'b0;
    case (state)
      EMPTY: if (push) begin
        state_nx     = ONE;
        load_head_in = 1'b1;
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_nx  = TWO;
          load_slot = 1'b1;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      TWO: if (pop) begin
        state_nx       = ONE;
        load_head_slot = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Head registers drive out_* directly and keep the last value once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sel     <= '0;
      out_result  <= '0;
      head_flags  <= '0;
      slot_sel    <= '0;
      slot_result <= '0;
      slot_flags  <= '0;
    end else begin
      if (load_head_in) begin
        out_sel    <= in_sel;
        out_result <= in_result;
        head_flags <= in_flags;
      end else if (load_head_slot) begin
        out_sel    <= slot_sel;
        out_result <= slot_result;
        head_flags <= slot_flags;
      end
      if (load_slot) begin
        slot_sel    <= in_sel;
        slot_result <= in_result;
        slot_flags  <= in_flags;
      end
    end
  end

  assign out_zero = head_flags.zero;
  assign out_neg  = head_flags.neg;
  assign out_ovf  = head_flags.ovf;

`ifdef ALU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count     <= '0;
      stat_ovf_count <= '0;
    end else if (stat_clr) begin
      stat_count     <= '0;
      stat_ovf_count <= '0;
    end else begin
      if (pop && (stat_count != 16'hFFFF)) begin
        stat_count <= stat_count + 16'd1;
      end
      if (pop && head_flags.ovf && (stat_ovf_count != 16'hFFFF)) begin
        stat_ovf_count <= stat_ovf_count + 16'd1;
      end
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_count      = '0;
  assign stat_ovf_count  = '0;
`endif

endmodule
